psk_rx_sched: RTL
=================

# psk_rx_sched

Receive-side symbol scheduler and framer placed directly after the PSK hard-decision detector. It counts detector-valid samples to pick one decision per symbol. It then searches the decision bit stream for a sync word and packs the following payload into bytes. Bytes leave on an AXI-Stream-style byte interface toward the MAC/UART layer.

## Interface
- `SPS`, 8: detector samples per symbol; legal range 2..255.
- `SAMPLE_PHASE`, 4: sample index within a symbol that is used as the decision; must be < `SPS`.
- `SYNC_WORD`, 16'hE5A3: sync pattern, compared MSB = oldest bit.
- `PAYLOAD_BYTES`, 64: bytes per frame after sync; legal range 1..255.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: run enable; low forces IDLE.
- `mode` in 1: 0 = BPSK, 1 = QPSK; latched on IDLE→SEARCH.
- `det_bpsk` in 1: detector BPSK decision.
- `det_qpsk` in 2: detector QPSK dibit, {I sign, Q sign}.
- `det_vld` in 1: detector sample valid.
- `m_tdata` out 8: payload byte.
- `m_tvalid` out 1: byte valid.
- `m_tready` in 1: downstream accept.
- `m_tlast` out 1: marks the last byte of a frame.
- `locked` out 1: high while in PAYLOAD.
- `ovf` out 1: sticky overflow flag (a byte was dropped).

## Operation
- States: IDLE, SEARCH, PAYLOAD.
  - IDLE→SEARCH when `en`=1. On entry: latch `mode`; clear the sample counter, the sync shift register and the bit and byte counters; clear `ovf`.
  - Any state→IDLE when `en`=0. The frame in progress is aborted and its partial byte is discarded.
- Sample counter `scnt`:
  - Runs only in SEARCH and PAYLOAD.
  - Increments on each `det_vld` and wraps from `SPS-1` to 0.
  - Symbol strobe = `det_vld` && `scnt==SAMPLE_PHASE`.
- Bits per strobe:
  - BPSK: one bit, `det_bpsk`.
  - QPSK: two bits, `det_qpsk[1]` first, then `det_qpsk[0]`.
- SEARCH:
  - On each strobe, shift the new bit(s) into the 16-bit sync register, LSB side.
  - Compare the post-shift value to `SYNC_WORD`. In QPSK the comparison is made only after both bits are in.
  - On a match, move to PAYLOAD on that same edge, with bit count 0 and byte count 0.
- PAYLOAD:
  - Pack bits MSB-first into a byte.
  - On the strobe that completes 8 bits, load `m_tdata` and assert `m_tvalid`.
  - Assert `m_tlast` if the byte count is `PAYLOAD_BYTES-1`.
  - After the last byte, return to SEARCH with the sync register cleared to 0.
- Output handshake:
  - `m_tvalid` holds until `m_tvalid && m_tready`, then clears.
  - If a new byte completes while a byte is still held, the new byte is dropped and `ovf` is set.
  - The byte count still advances, so frame length is preserved and `m_tlast` may be lost.
  - A byte pending when the block enters IDLE stays valid until accepted.
  - If a handshake and a new byte occur on the same edge, the new byte is loaded and no overflow is flagged.
- Reset values:
  - State = IDLE; `m_tdata`=0, `m_tvalid`=0, `m_tlast`=0, `locked`=0, `ovf`=0.
  - All counters and the sync register = 0.

## Timing
- All outputs are registered.
- Strobe to sync-match state change: same clock edge as the shift, so `locked` rises 1 cycle after the strobe cycle.
- Completing strobe to `m_tvalid` high: 1 cycle.
- `SPS`≥2 guarantees at least 2 cycles between strobes, so one output stage is enough when the sink is ready.
- `det_vld` samples are ignored in IDLE.
- `mode` changes outside IDLE have no effect.
- `en` falling takes effect on the next edge. A strobe in that cycle is ignored.

## Configuration
- `PSK_RX_SCHED_PHASE_INV_EN`, defined:
  - SEARCH also matches `~SYNC_WORD`, which resolves 180° carrier ambiguity.
  - On an inverted match, an internal `inv` flag is set and every payload bit is inverted before packing.
  - `inv` is cleared on entry to SEARCH.
- Undefined: only the true `SYNC_WORD` matches, and no inversion logic is present.

## Test plan
- BPSK, `SPS`=8, `det_vld` continuous, sync bits E5A3 followed by payload bytes 0x00..0x3F:
  - `locked` rises 1 cycle after the 16th strobe.
  - 64 bytes 0x00..0x3F are emitted, with `m_tlast` on 0x3F.
  - The block returns to SEARCH.
- QPSK with the same data at 2 bits per symbol:
  - Sync is found after 8 strobes.
  - Each byte completes every 4 strobes; output bytes are identical.
- `m_tready`=0 for 20 symbols in PAYLOAD (BPSK):
  - The first byte is held.
  - Following completed bytes are dropped and `ovf`=1.
  - Byte count still ends the frame after 64 bytes.
- `en` dropped after 10 payload bytes:
  - Next edge: IDLE, `locked`=0.
  - A pending byte completes its handshake.
  - Re-enabling clears `ovf` and restarts the search.
- Sync E5A2 (one-bit error): no lock, no output.
  - With the macro defined, 1A5C locks and payload 0xFF is output as 0x00.
- `rst` pulsed mid-frame with `m_tvalid`=1: all outputs are 0 immediately (asynchronous), and the state is IDLE.

Source files
------------

// File: rtl/psk_rx_sched_if.sv
// Byte stream from the PSK receive scheduler toward the MAC/UART layer.
// The scheduler drives the master side; the consumer drives m_tready.
interface psk_rx_sched_if;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/psk_rx_sched.sv
// PSK receive symbol scheduler and framer: picks one decision per symbol, finds the sync word, packs payload bytes.
// Optional feature macro PSK_RX_SCHED_PHASE_INV_EN: also lock on the inverted sync word and invert the payload bits.
module psk_rx_sched #(
    parameter int unsigned SPS           = 8,
    parameter int unsigned SAMPLE_PHASE  = 4,
    parameter logic [15:0] SYNC_WORD     = 16'hE5A3,
    parameter int unsigned PAYLOAD_BYTES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  det_bpsk,
    input  logic [1:0]            det_qpsk,
    input  logic                  det_vld,
    psk_rx_sched_if.master        axis,
    output logic                  locked,
    output logic                  ovf
);
    localparam logic [7:0] PHASE  = 8'(SAMPLE_PHASE);
    localparam logic [7:0] LAST_S = 8'(SPS - 1);
    localparam logic [7:0] LAST_B = 8'(PAYLOAD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, PAYLOAD} state_t;

    state_t      state;
    logic        mode_q;
    logic [7:0]  scnt;
    logic [14:0] sync_sr;
    logic [6:0]  byte_sr;
    logic [3:0]  bcnt;
    logic [7:0]  byte_cnt;

    logic [7:0]  tdata_p1;
    logic        vld_p1;
    logic        tlast_p1;
    logic        locked_q;
    logic        ovf_q;

    logic        strobe;
    logic [7:0]  scnt_nxt;
    logic [15:0] sync_nxt;
    logic        sync_hit;
    logic        sync_hit_inv;
    logic [1:0]  pb;
    logic [7:0]  byte_nxt;
    logic [3:0]  bcnt_nxt;
    logic        byte_done;
    logic        last_byte;
    logic        hs;

`ifdef PSK_RX_SCHED_PHASE_INV_EN
    logic        inv;
`endif

    // Stage p0: decision selection, sync compare and byte packing
    always_comb begin
        strobe   = det_vld && (scnt == PHASE);
        scnt_nxt = (scnt == LAST_S) ? 8'd0 : scnt + 8'd1;
        sync_nxt = mode_q ? {sync_sr[13:0], det_qpsk} : {sync_sr, det_bpsk};
        sync_hit = (sync_nxt == SYNC_WORD);
`ifdef PSK_RX_SCHED_PHASE_INV_EN
        sync_hit_inv = (sync_nxt == ~SYNC_WORD);
        pb           = mode_q ? (det_qpsk ^ {2{inv}}) : {1'b0, det_bpsk ^ inv};
`else
        sync_hit_inv = 1'b0;
        pb           = mode_q ? det_qpsk : {1'b0, det_bpsk};
`endif
        byte_nxt  = mode_q ? {byte_sr[5:0], pb} : {byte_sr, pb[0]};
        bcnt_nxt  = bcnt + (mode_q ? 4'd2 : 4'd1);
        byte_done = bcnt_nxt[3];
        last_byte = (byte_cnt == LAST_B);
        hs        = vld_p1 && axis.m_tready;
    end

    // Stage p1: framing state and the single registered output byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            scnt     <= 8'd0;
            sync_sr  <= 15'd0;
            byte_sr  <= 7'd0;
            bcnt     <= 4'd0;
            byte_cnt <= 8'd0;
            tdata_p1 <= 8'd0;
            vld_p1   <= 1'b0;
            tlast_p1 <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef PSK_RX_SCHED_PHASE_INV_EN
            inv      <= 1'b0;
`endif
        end else begin
            // A held byte drains even while the framer is idle.
            if (hs) begin
                vld_p1   <= 1'b0;
                tlast_p1 <= 1'b0;
            end

            if (!en) begin
                state    <= IDLE;
                locked_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= SEARCH;
                        mode_q   <= mode;
                        scnt     <= 8'd0;
                        sync_sr  <= 15'd0;
                        bcnt     <= 4'd0;
                        byte_cnt <= 8'd0;
                        ovf_q    <= 1'b0;
`ifdef PSK_RX_SCHED_PHASE_INV_EN
                        inv      <= 1'b0;
`endif
                    end
                    SEARCH: begin
                        if (det_vld) scnt <= scnt_nxt;
                        if (strobe) begin
                            sync_sr <= sync_nxt[14:0];
                            if (sync_hit || sync_hit_inv) begin
                                state    <= PAYLOAD;
                                locked_q <= 1'b1;
                                bcnt     <= 4'd0;
                                byte_cnt <= 8'd0;
`ifdef PSK_RX_SCHED_PHASE_INV_EN
                                inv      <= sync_hit_inv;
`endif
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (det_vld) scnt <= scnt_nxt;
                        if (strobe) begin
                            byte_sr <= byte_nxt[6:0];
                            bcnt    <= byte_done ? 4'd0 : bcnt_nxt;
                            if (byte_done) begin
                                // A byte completing while one is still held is lost, but still counted.
                                if (!vld_p1 || hs) begin
                                    tdata_p1 <= byte_nxt;
                                    vld_p1   <= 1'b1;
                                    tlast_p1 <= last_byte;
                                end else begin
                                    ovf_q <= 1'b1;
                                end
                                if (last_byte) begin
                                    state    <= SEARCH;
                                    locked_q <= 1'b0;
                                    sync_sr  <= 15'd0;
                                    byte_cnt <= 8'd0;
`ifdef PSK_RX_SCHED_PHASE_INV_EN
                                    inv      <= 1'b0;
`endif
                                end else begin
                                    byte_cnt <= byte_cnt + 8'd1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign axis.m_tdata  = tdata_p1;
    assign axis.m_tvalid = vld_p1;
    assign axis.m_tlast  = tlast_p1;
    assign locked        = locked_q;
    assign ovf           = ovf_q;

endmodule
